// File: rtl/node_info_ctrl_pkg.sv
// node_info_pkg: shared constants and types for the node_info_ctrl slice.
//   PKT_*       - 3-bit packet type codes seen on fPktType
//   hb_state_t  - heartbeat lock FSM state encoding
//   pkt_is()    - "accepted packet of this type" decode helper
package node_info_pkg;

  localparam logic [2:0] PKT_HB   = 3'b000;
  localparam logic [2:0] PKT_CH   = 3'b001;
  localparam logic [2:0] PKT_SLOT = 3'b100;
  localparam logic [2:0] PKT_DATA = 3'b101;

  typedef enum logic {
    HB_UNLOCKED = 1'b0,
    HB_LOCKED   = 1'b1
  } hb_state_t;

  function automatic logic pkt_is(input logic en, input logic [2:0] typ,
                                  input logic [2:0] want);
    return en && (typ == want);
  endfunction

endpackage

// File: rtl/node_info_ctrl_if.sv
// node_info_ctrl_if: bundles the decoder-side packet fields and the
// node-state outputs of node_info_ctrl.
//   master - packet decoder / routing side: drives fields, reads state
//   slave  - node_info_ctrl: reads fields, drives state
// Parameter DATA_W sets the width of every data field.
interface node_info_ctrl_if #(
  parameter int DATA_W = 16
);
  import node_info_pkg::*;

  logic              en_MNI;
  logic [2:0]        fPktType;
  logic [DATA_W-1:0] e_max;
  logic [DATA_W-1:0] e_min;
  logic [DATA_W-1:0] energy;
  logic [DATA_W-1:0] ch_ID;
  logic [DATA_W-1:0] hops;
  logic [DATA_W-1:0] timeslot;
  logic [DATA_W-1:0] e_threshold;
  logic [DATA_W-1:0] q_in;
  logic              q_valid;

  logic [DATA_W-1:0] myNodeID;
  logic [DATA_W-1:0] hopsFromSink;
  logic [DATA_W-1:0] myQValue;
  logic [DATA_W-1:0] e_min_o;
  logic [DATA_W-1:0] e_max_o;
  logic [DATA_W-1:0] e_thr_o;
  logic              role;
  logic              low_E;
  logic              hb_locked;
  logic              slot_start;
  logic              slot_active;

  modport master (
    output en_MNI, fPktType, e_max, e_min, energy, ch_ID, hops, timeslot,
           e_threshold, q_in, q_valid,
    input  myNodeID, hopsFromSink, myQValue, e_min_o, e_max_o, e_thr_o,
           role, low_E, hb_locked, slot_start, slot_active
  );

  modport slave (
    input  en_MNI, fPktType, e_max, e_min, energy, ch_ID, hops, timeslot,
           e_threshold, q_in, q_valid,
    output myNodeID, hopsFromSink, myQValue, e_min_o, e_max_o, e_thr_o,
           role, low_E, hb_locked, slot_start, slot_active
  );

endinterface

// File: rtl/node_info_ctrl_slot_timer.sv
// node_slot_timer: TDMA slot down-counter.
//   clk, rst    - clock, synchronous active-high reset
//   load, value - (re)start the countdown from value
//   slot_start  - one-cycle registered pulse when the armed count hits 0
//   armed       - countdown in progress
// A load always wins over an expiring count, so a reload mid-count never
// produces a pulse for the old slot. The counter stops at 0 and never wraps.
module node_slot_timer #(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [DATA_W-1:0] value,
  output logic              slot_start,
  output logic              armed
);
  import node_info_pkg::*;

  logic [DATA_W-1:0] r_cnt;
  logic              r_armed;
  logic              r_slot_start;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt        <= '0;
      r_armed      <= 1'b0;
      r_slot_start <= 1'b0;
    end else begin
      r_slot_start <= 1'b0;
      if (load) begin
        r_cnt   <= value;
        r_armed <= 1'b1;
      end else if (r_armed) begin
        if (r_cnt == '0) begin
          r_slot_start <= 1'b1;
          r_armed      <= 1'b0;
        end else begin
          r_cnt <= r_cnt - DATA_W'(1);
        end
      end
    end
  end

  assign slot_start = r_slot_start;
  assign armed      = r_armed;

endmodule

// File: rtl/node_info_ctrl.sv
// node_info_ctrl: per-node state block for the EER-RL clustering node.
// Latches round parameters from the first heartbeat, tracks minimum hop
// count, derives cluster-head role and a hysteretic low-energy flag, holds
// the Q-value and times the node's TDMA slot.
//   clk, rst - clock, synchronous active-high reset
//   bus      - node_info_ctrl_if.slave: packet fields in, node state out
// Build option: NODE_INFO_LOWE_RESIGN_EN - when defined, a set low_E flag
// forces role to 0 (node resigns cluster head), overriding CH packets.
//
// state       | meaning
// HB_UNLOCKED | waiting for a heartbeat; next HB latches round parameters
// HB_LOCKED   | round parameters held; HB only lowers hop count; timer runs
module node_info_ctrl #(
  parameter int                DATA_W     = 16,
  parameter logic [DATA_W-1:0] NODE_ID    = DATA_W'(16'h000C),
  parameter int                HB_TIMEOUT = 1024,
  parameter logic [DATA_W-1:0] E_HYST     = DATA_W'(32)
) (
  input  logic              clk,
  input  logic              rst,
  node_info_ctrl_if.slave   bus
);
  import node_info_pkg::*;

  localparam int TW = (HB_TIMEOUT > 1) ? $clog2(HB_TIMEOUT + 1) : 1;

  hb_state_t         r_state;
  logic [TW-1:0]     r_hb_timer;
  logic              r_hb_locked;
  logic [DATA_W-1:0] r_hops;
  logic [DATA_W-1:0] r_e_min;
  logic [DATA_W-1:0] r_e_max;
  logic [DATA_W-1:0] r_e_thr;
  logic [DATA_W-1:0] r_q;
  logic              r_role;
  logic              r_low_E;
  logic              r_slot_active;

  logic              w_hb;
  logic              w_ch;
  logic              w_slot;
  logic              w_data;
  logic              w_hb_clear_slot;
  logic [DATA_W:0]   w_thr_sum;
  logic [DATA_W-1:0] w_lowe_release;
  logic              w_slot_start;
  logic              w_slot_armed;

  assign w_hb   = pkt_is(bus.en_MNI, bus.fPktType, PKT_HB);
  assign w_ch   = pkt_is(bus.en_MNI, bus.fPktType, PKT_CH);
  assign w_slot = pkt_is(bus.en_MNI, bus.fPktType, PKT_SLOT);
  assign w_data = pkt_is(bus.en_MNI, bus.fPktType, PKT_DATA);

  // Only the locking heartbeat starts a new round and gives up the slot.
  assign w_hb_clear_slot = w_hb && (r_state == HB_UNLOCKED);

  // Release threshold is computed one bit wider and clamped to all-ones.
  assign w_thr_sum      = {1'b0, r_e_thr} + {1'b0, E_HYST};
  assign w_lowe_release = w_thr_sum[DATA_W] ? '1 : w_thr_sum[DATA_W-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= HB_UNLOCKED;
      r_hb_timer  <= '0;
      r_hb_locked <= 1'b0;
      r_hops      <= '0;
      r_e_min     <= '0;
      r_e_max     <= '0;
      r_e_thr     <= '0;
    end else begin
      case (r_state)
        HB_UNLOCKED: begin
          if (w_hb) begin
            r_hops      <= bus.hops;
            r_e_min     <= bus.e_min;
            r_e_max     <= bus.e_max;
            r_e_thr     <= bus.e_threshold;
            r_hb_timer  <= TW'(HB_TIMEOUT);
            r_state     <= HB_LOCKED;
            r_hb_locked <= 1'b1;
          end
        end
        HB_LOCKED: begin
          // An HB in the release cycle lands here too: hop update only.
          if (w_hb && (bus.hops < r_hops)) begin
            r_hops <= bus.hops;
          end
          if (r_hb_timer != '0) begin
            r_hb_timer <= r_hb_timer - TW'(1);
          end
          if (w_data || (r_hb_timer == TW'(1))) begin
            r_state     <= HB_UNLOCKED;
            r_hb_locked <= 1'b0;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_role <= 1'b0;
    end else begin
`ifdef NODE_INFO_LOWE_RESIGN_EN
      if (r_low_E) begin
        r_role <= 1'b0;
      end else if (w_ch) begin
        r_role <= (bus.ch_ID == NODE_ID);
      end
`else
      if (w_ch) begin
        r_role <= (bus.ch_ID == NODE_ID);
      end
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_low_E <= 1'b0;
    end else if (bus.energy < r_e_thr) begin
      r_low_E <= 1'b1;
    end else if (bus.energy >= w_lowe_release) begin
      r_low_E <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_q <= '0;
    end else if (bus.q_valid) begin
      r_q <= bus.q_in;
    end
  end

  node_slot_timer #(
    .DATA_W (DATA_W)
  ) u_slot_timer (
    .clk        (clk),
    .rst        (rst),
    .load       (w_slot),
    .value      (bus.timeslot),
    .slot_start (w_slot_start),
    .armed      (w_slot_armed)
  );

  // The sticky flag lags the pulse by a cycle; OR-ing in the pulse makes
  // slot_active rise together with slot_start.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_slot_active <= 1'b0;
    end else if (w_slot || w_hb_clear_slot) begin
      r_slot_active <= 1'b0;
    end else if (w_slot_start) begin
      r_slot_active <= 1'b1;
    end else if (w_slot_armed) begin
      r_slot_active <= 1'b0;
    end
  end

  assign bus.myNodeID     = NODE_ID;
  assign bus.hopsFromSink = r_hops;
  assign bus.myQValue     = r_q;
  assign bus.e_min_o      = r_e_min;
  assign bus.e_max_o      = r_e_max;
  assign bus.e_thr_o      = r_e_thr;
  assign bus.role         = r_role;
  assign bus.low_E        = r_low_E;
  assign bus.hb_locked    = r_hb_locked;
  assign bus.slot_start   = w_slot_start;
  assign bus.slot_active  = r_slot_active | w_slot_start;

endmodule

// File: doc/node_info_ctrl.md
# node_info_ctrl

Parametrised per-node state block for the EER-RL clustering node. It latches round parameters from the first accepted heartbeat and tracks minimum hop count. It also derives cluster-head role and a hysteretic low-energy flag, holds the Q-value from the Q-compute unit, and times the node's TDMA slot. It sits between the packet decoder (which drives `en_MNI`/`fPktType` and field buses) and the routing/MAC logic.

## Interface
- `DATA_W`, 16: width of all data fields.
- `NODE_ID`, 16'h000C: this node's ID (DATA_W bits).
- `HB_TIMEOUT`, 1024: cycles after lock before automatic heartbeat-lock release; must be ≥1.
- `E_HYST`, 16'd32: low-energy release hysteresis.

Ports:
- `clk`  in  1  clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `en_MNI`  in  1  decoded packet fields valid this cycle.
- `fPktType`  in  3  packet type.
- `e_max`, `e_min`, `energy`, `ch_ID`, `hops`, `timeslot`, `e_threshold`  in  DATA_W  packet/measurement fields.
- `q_in`  in  DATA_W  Q-value from the compute unit.
- `q_valid`  in  1  `q_in` valid.
- `myNodeID`  out  DATA_W  constant `NODE_ID`.
- `hopsFromSink`, `myQValue`, `e_min_o`, `e_max_o`, `e_thr_o`  out  DATA_W  latched values.
- `role`  out  1  1 = cluster head.
- `low_E`  out  1  low-energy flag.
- `hb_locked`  out  1  heartbeat lock state.
- `slot_start`  out  1  one-cycle pulse at slot start.
- `slot_active`  out  1  slot owned.

## Operation
- Packet is accepted only when `en_MNI`=1. Packet types: HB=000, CH=001, SLOT=100, DATA=101. Others are ignored.
- HB lock FSM states are UNLOCKED and LOCKED.
  - In UNLOCKED, an accepted HB captures `hops`, `e_min`, `e_max` and `e_threshold` into `hopsFromSink`, `e_min_o`, `e_max_o` and `e_thr_o`. It also clears `slot_active`, loads the timer with HB_TIMEOUT and moves to LOCKED.
  - In LOCKED, an accepted HB updates only `hopsFromSink`, and only when `hops` < `hopsFromSink` (unsigned).
  - In LOCKED, the timer decrements each cycle. An accepted DATA packet or the timer reaching 1 returns the FSM to UNLOCKED on the next edge.
  - An HB arriving in the release cycle is treated as a LOCKED HB.
- Role: an accepted CH packet sets `role` = (`ch_ID` == NODE_ID). Otherwise `role` holds.
- Low energy:
  - Set when `energy` < `e_thr_o`.
  - Cleared when `energy` ≥ `e_thr_o` + E_HYST. The sum saturates at 2^DATA_W−1.
  - Otherwise `low_E` holds.
  - It is evaluated every cycle regardless of `en_MNI`.
- Q-value: `myQValue` loads `q_in` when `q_valid`=1. Otherwise it holds.
- Slot timer:
  - An accepted SLOT packet loads the counter with `timeslot`, arms the timer and clears `slot_active`.
  - While armed, the counter decrements by 1 per cycle.
  - When the armed counter is 0, `slot_start` pulses, `slot_active` sets and the timer disarms.
  - `timeslot`=0 gives a pulse on the cycle after the load.
  - A reload mid-count restarts the timer.
  - The counter never wraps.

## Timing
- All outputs are registered and reflect inputs sampled at the preceding edge (1-cycle latency).
- Reset values:
  - `hopsFromSink`, `myQValue`, `e_min_o`, `e_max_o`, `e_thr_o`: 0.
  - `role`, `low_E`, `hb_locked`, `slot_start`, `slot_active`: 0.
  - FSM: UNLOCKED. Slot timer: disarmed.
- Because `e_thr_o`=0 after reset, `low_E` stays 0 until the first HB.
- Reset mid-countdown or mid-lock aborts immediately. No pulse is emitted.
- `slot_start` is high for exactly one cycle per armed load.

## Configuration
- `NODE_INFO_LOWE_RESIGN_EN`
  - Defined: the cycle `low_E` is 1 forces `role` to 0. This takes priority over a simultaneous CH packet. The node resigns cluster head.
  - Undefined: `role` depends only on CH packets.

## Structure
- Package `node_info_pkg` holds the packet type constants (PKT_HB, PKT_CH, PKT_SLOT, PKT_DATA) and the `hb_state_t` enum {HB_UNLOCKED, HB_LOCKED}.
- Sub-module `node_slot_timer` (DATA_W parameter; inputs load, value; outputs slot_start, armed) implements the slot countdown. All other logic is in `node_info_ctrl`.

## Test plan
- HB hops=5, e_min=10, e_max=200, e_threshold=50, then HB hops=7, then HB hops=3 → first HB latches all fields and `hb_locked`=1; `hopsFromSink` sequence is 5, 5, 3.
- HB_TIMEOUT=8, one HB, no DATA → `hb_locked` falls 8 cycles later; next HB with e_min=20 latches `e_min_o`=20.
- `e_thr_o`=50, E_HYST=32, energy sweep 60, 49, 70, 81, 82 → `low_E` sequence 0, 1, 1, 1, 0.
- CH packet with `ch_ID`=16'h000C → `role`=1; CH packet with `ch_ID`=16'h0003 → `role`=0. With the macro defined, `low_E` rising forces `role`=0.
- SLOT with `timeslot`=4 → `slot_start` pulses 5 cycles after acceptance, then `slot_active`=1. SLOT with `timeslot`=0 → pulse 1 cycle after acceptance.
- `rst` asserted mid-countdown and while locked → all outputs 0 next edge; no `slot_start` afterwards.
